// File: rtl/axi_stall_ctrl.sv
// Valid/ready stall injector: holds each upstream request for a fixed or
// LFSR-randomised number of cycles before presenting it downstream.
module axi_stall_ctrl #(
  parameter int unsigned DelayWidth = 8,
  parameter logic [15:0] LfsrSeed   = 16'hACE1,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  rand_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CntWidth-1:0]   stall_cnt_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, COUNT, PASS} state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LfsrTaps = 16'hB400;

  state_e                state_q, state_d;
  logic [DelayWidth-1:0] cnt_q, cnt_d;
  logic [DelayWidth-1:0] load_val;
  logic [15:0]           lfsr_q, lfsr_d, lfsr_step;
  logic [CntWidth-1:0]   stall_q, stall_d;
  logic                  err_q, err_d;
  logic                  err_ev, stall_ev;

  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  assign load_val  = rand_i ? (lfsr_q[DelayWidth-1:0] & delay_i) : delay_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    valid_o = 1'b0;
    ready_o = 1'b0;
    err_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          if (valid_i) begin
            state_d = COUNT;
            cnt_d   = load_val;
            lfsr_d  = lfsr_step;
          end
        end else begin
          valid_o = valid_i;
          ready_o = ready_i;
          // a valid already shown downstream must be held until accepted
          if (valid_i && !ready_i) state_d = PASS;
        end
      end
      COUNT: begin
        if (!valid_i) begin
          err_ev  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = PASS;
        end else begin
          cnt_d = cnt_q - DelayWidth'(1);
        end
      end
      PASS: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (!valid_i) begin
          err_ev  = 1'b1;
          state_d = IDLE;
        end else if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      valid_o = 1'b0;
      ready_o = 1'b0;
    end
  end

  assign stall_ev = valid_i && !ready_o;

  always_comb begin
    stall_d = stall_q;
    if (clear_i)                      stall_d = '0;
    else if (stall_ev && !(&stall_q)) stall_d = stall_q + CntWidth'(1);
    // an error in the same cycle as a clear must survive it
    err_d = err_ev || (err_q && !clear_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LfsrSeed;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_axi_stall_ctrl.sv
// Directed bench for axi_stall_ctrl with a transaction-level reference model
// checked every cycle on the falling edge.
module tb_axi_stall_ctrl;
  localparam int          DW   = 8;
  localparam int          CW   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1, en = 1'b1, rnd = 1'b0, clear = 1'b0;
  logic          vin = 1'b0, rdy_in = 1'b0;
  logic          vout, rdy_out, err;
  logic [DW-1:0] delay = '0;
  logic [CW-1:0] stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_stall_ctrl #(.DelayWidth(DW), .LfsrSeed(SEED), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .rand_i(rnd), .delay_i(delay),
    .clear_i(clear), .valid_i(vin), .ready_o(rdy_out), .valid_o(vout),
    .ready_i(rdy_in), .stall_cnt_o(stall), .err_o(err)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a transfer in flight waits m_wait cycles, then presents valid
  bit          m_armed = 0;
  bit          m_busy  = 0;
  int          m_wait  = 0;
  logic [15:0] m_lfsr  = SEED;
  int          m_stall = 0;
  bit          m_err   = 0;

  function automatic logic [1:0] exp_vr();
    if (rst)         return 2'b00;
    if (!m_busy)     return en ? 2'b00 : {vin, rdy_in};
    if (m_wait > 0)  return 2'b00;
    return {1'b1, rdy_in};
  endfunction

  always @(posedge clk) begin
    logic [1:0] vr;
    int         l;
    vr = exp_vr();
    if (rst) begin
      m_armed = 1; m_busy = 0; m_wait = 0; m_lfsr = SEED; m_stall = 0; m_err = 0;
    end else begin
      if (vin && !vr[0] && m_stall < (1 << CW) - 1) m_stall++;
      if (clear) m_stall = 0;
      m_err = (m_err && !clear) || (m_busy && !vin);
      if (!m_busy) begin
        if (en && vin) begin
          l      = rnd ? int'(m_lfsr[DW-1:0] & delay) : int'(delay);
          m_busy = 1;
          m_wait = l + 1;
          m_lfsr = lfsr_next(m_lfsr);
        end else if (!en && vin && !rdy_in) begin
          m_busy = 1;
          m_wait = 0;
        end
      end else if (!vin) begin
        m_busy = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rdy_in) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] vr;
    if (m_armed) begin
      vr = exp_vr();
      chk("cyc_valid_o", vout, vr[1]);
      chk("cyc_ready_o", rdy_out, vr[0]);
      chk("cyc_stall_cnt_o", stall, m_stall);
      chk("cyc_err_o", err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until the handshake is seen; lat = cycles from valid_i rise to handshake
  task automatic run_xfer(input bit drop, output int lat);
    lat    = -1;
    vin    = 1'b1;
    rdy_in = 1'b1;
    for (int c = 0; c < 64; c++) begin
      #2;
      if (vout && rdy_out) begin
        lat = c;
        step();
        if (drop) vin = 1'b0;
        return;
      end
      step();
    end
    vin = 1'b0;
  endtask

  initial begin
    int          lat, tot;
    logic [15:0] rf;

    // reset gates outputs even in transparent mode
    rst = 1; en = 0; vin = 1; rdy_in = 1;
    step(); step();
    #2 chk("rst_valid_o", vout, 0);
    chk("rst_ready_o", rdy_out, 0);
    rst = 0; vin = 0; rdy_in = 0; en = 1;
    step();
    #2 chk("post_rst_stall", stall, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_valid_o", vout, 0);
    step();

    // fixed delay 3
    rnd = 0; delay = 3;
    run_xfer(1, lat);
    chk("fixed3_lat", lat, 5);
    #2 chk("fixed3_stall", stall, 5);
    chk("fixed3_ready_after", rdy_out, 0);
    step();

    // zero delay, four back-to-back transfers
    clear = 1; step(); clear = 0;
    #2 chk("clear_stall", stall, 0);
    step();
    delay = 0; tot = 0;
    for (int i = 0; i < 4; i++) begin
      run_xfer(i == 3, lat);
      chk("zero_lat", lat, 2);
      tot += lat + 1;
    end
    chk("b2b_total", tot, 12);
    #2 chk("b2b_stall", stall, 8);
    step();

    // transparent mode; en rising mid-PASS must not matter
    en = 0; vin = 1; rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("transp_valid_o", vout, 1);
      step();
    end
    en = 1;
    #2 chk("transp_en_valid_o", vout, 1);
    chk("transp_en_ready_o", rdy_out, 0);
    step();
    rdy_in = 1;
    #2 chk("transp_hs_valid_o", vout, 1);
    chk("transp_hs_ready_o", rdy_out, 1);
    step();
    vin = 0;
    #2 chk("transp_done_valid_o", vout, 0);
    step();

    // random load after 5 prior loads; transparent pass must not have stepped the LFSR
    rf = SEED;
    for (int i = 0; i < 5; i++) rf = lfsr_next(rf);
    rnd = 1; delay = 8'h0F;
    run_xfer(1, lat);
    chk("rand_after_transp_lat", lat, int'(rf[3:0]) + 2);
    rnd = 0;
    step();

    // protocol error in COUNT, with clear colliding with a stall increment first
    delay = 5; rdy_in = 1; vin = 1;
    #2 chk("err_idle_valid_o", vout, 0);
    step();
    clear = 1; step(); clear = 0;
    #2 chk("clear_vs_inc", stall, 0);
    vin = 0;
    step();
    en = 0; vin = 1;
    #2 chk("err_set", err, 1);
    chk("err_idle_transp_valid", vout, 1);
    chk("err_idle_transp_ready", rdy_out, 1);
    step();
    vin = 0; en = 1; clear = 1;
    step(); clear = 0;
    #2 chk("err_cleared", err, 0);
    step();

    // error coinciding with clear must leave err set
    vin = 1; step();
    vin = 0; clear = 1; step(); clear = 0;
    #2 chk("err_vs_clear", err, 1);
    clear = 1; step(); clear = 0;
    #2 chk("err_cleared2", err, 0);
    step();

    // reset mid-PASS
    delay = 1; rdy_in = 0; vin = 1;
    step(); step(); step();
    #2 chk("pass_before_rst", vout, 1);
    rst = 1; step();
    #2 chk("rst_pass_valid_o", vout, 0);
    chk("rst_pass_stall", stall, 0);
    rst = 0; vin = 0;
    #1 chk("rst_pass_idle_valid_o", vout, 0);
    step();

    // random mode, 1000 back-to-back transfers from a fresh seed
    rnd = 1; delay = 8'h0F; rf = SEED;
    for (int i = 0; i < 1000; i++) begin
      run_xfer(i == 999, lat);
      if (i == 0) chk("first_rand_lat", lat, 3);
      chk("rand_lat", lat, int'(rf[DW-1:0] & delay) + 2);
      chk("rand_range", (lat >= 2 && lat <= 17) ? 1 : 0, 1);
      rf = lfsr_next(rf);
    end
    #2 chk("stall_saturated", stall, 15);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_stall_ctrl.md
AXI_STALL_CTRL -- requirements
Module: axi_stall_ctrl

Interface
REQ-001 The block SHALL have parameter DelayWidth, default 8, giving the delay counter width; legal range 1..16.
REQ-002 The block SHALL have parameter LfsrSeed, default 16'hACE1, giving the LFSR reset value; it SHALL be nonzero.
REQ-003 The block SHALL have parameter CntWidth, default 32, giving the stall statistics counter width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en_i, input, 1 bit: 1 = apply delay, 0 = transparent.
REQ-007 The block SHALL have port rand_i, input, 1 bit: 1 = random delay, 0 = fixed delay.
REQ-008 The block SHALL have port delay_i, input, DelayWidth bits: fixed delay value, or mask in random mode.
REQ-009 The block SHALL have port clear_i, input, 1 bit: synchronous clear of stall_cnt_o and err_o.
REQ-010 The block SHALL have port valid_i, input, 1 bit: upstream valid.
REQ-011 The block SHALL have port ready_o, output, 1 bit: upstream ready.
REQ-012 The block SHALL have port valid_o, output, 1 bit: downstream valid.
REQ-013 The block SHALL have port ready_i, input, 1 bit: downstream ready.
REQ-014 The block SHALL have port stall_cnt_o, output, CntWidth bits: number of cycles stalled.
REQ-015 The block SHALL have port err_o, output, 1 bit: sticky flag for upstream protocol violation.
REQ-016 The block SHALL gate only the valid/ready handshake; the payload SHALL bypass the block externally.

Function
REQ-017 The block SHALL implement FSM states IDLE, COUNT and PASS, plus a DelayWidth-bit down-counter cnt.
REQ-018 Load value L SHALL be delay_i when rand_i=0, and lfsr[DelayWidth-1:0] & delay_i when rand_i=1.
REQ-019 In IDLE with en_i=1, outputs SHALL be valid_o=0 and ready_o=0.
REQ-020 In IDLE with en_i=1 and valid_i=1, the FSM SHALL go to COUNT, load cnt=L, and advance the LFSR one step.
REQ-021 In IDLE with en_i=0, outputs SHALL be valid_o=valid_i and ready_o=ready_i.
REQ-022 In IDLE with en_i=0, valid_i=1 and ready_i=0, the FSM SHALL go to PASS so the pending valid is not withdrawn.
REQ-023 In COUNT, outputs SHALL be valid_o=0 and ready_o=0; the FSM SHALL go to PASS when cnt==0, otherwise decrement cnt.
REQ-024 Latency from the first cycle valid_i=1 in IDLE to valid_o=1 SHALL be exactly L+2 cycles.
REQ-025 In PASS, outputs SHALL be valid_o=1 and ready_o=ready_i; when ready_i=1 the FSM SHALL return to IDLE in the next cycle.
REQ-026 en_i, rand_i and delay_i SHALL be sampled only at load time; changes during COUNT or PASS SHALL have no effect on the current transfer.
REQ-027 If valid_i=0 in COUNT or PASS, the FSM SHALL set err_o=1 and return to IDLE the next cycle; valid_o SHALL still stay 1 in that PASS cycle.
REQ-028 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 that advances only on a load.
REQ-029 stall_cnt_o SHALL increment by 1 in each cycle with valid_i=1 and ready_o=0, and SHALL saturate at all-ones.
REQ-030 clear_i SHALL set stall_cnt_o=0 and err_o=0 on the next edge.
REQ-031 If clear_i and an increment coincide, the result SHALL be 0.
REQ-032 If clear_i and an error event coincide, err_o SHALL be 1.
REQ-033 At most one handshake SHALL complete per PASS visit; back-to-back transfers SHALL each incur their own delay.

Reset
REQ-034 When rst_i=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, lfsr=LfsrSeed, stall_cnt_o=0 and err_o=0.
REQ-035 While rst_i=1, outputs SHALL be valid_o=0 and ready_o=0 regardless of en_i.
REQ-036 Reset asserted mid-COUNT or mid-PASS SHALL abort the transfer without completing a handshake.

Verification
REQ-037 The bench SHALL cover fixed delay: en=1, rand=0, delay=3, valid_i held, ready_i=1 -> valid_o rises at cycle 5, ready_o=1 for one cycle, stall_cnt_o=5.
REQ-038 The bench SHALL cover zero delay: delay=0, valid_i held, ready_i=1 -> handshake completes at cycle 2; 4 back-to-back transfers take 12 cycles.
REQ-039 The bench SHALL cover transparent mode: en=0, valid_i=1, ready_i=0 for 3 cycles, then en=1, then ready_i=1 -> valid_o stays 1 throughout and the handshake completes with no load.
REQ-040 The bench SHALL cover random mode: rand=1, delay=8'h0F, 1000 transfers -> every latency lies in 2..17 and matches a reference LFSR model seeded with 16'hACE1.
REQ-041 The bench SHALL cover protocol error: valid_i dropped during COUNT -> err_o=1 next cycle, state IDLE; then clear_i=1 -> err_o=0.
REQ-042 The bench SHALL cover reset mid-PASS: rst_i=1 for one cycle -> valid_o=0 and stall_cnt_o=0 next cycle; after reset, the first random load uses lfsr=16'hACE1.
